video_address_generator: RTL and testbench

- Generates the 13-bit display memory address (DA) and the alpha row-preset pulse for the VDG core.
- Sits between frame timing, which supplies the frame sync, line start and per-byte fetch strobes, and the external display RAM and pixel pipeline.
- Implements the per-mode bytes-per-line and row-repeat rules: 192, 96 and 64 row graphics, plus 12-line alpha/semigraphic character rows.

---
 rtl/video_address_generator.sv | 197 +++++++++++++++++++
 tb/tb_video_address_generator.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_address_generator.sv
// Display address generator for the VDG core.
// Produces the display RAM address for the next byte to fetch, the alpha
// character-row preset pulse, the scanline index within the current row
// repeat group, and a pulse flagging fetches that were ignored.
// Bytes-per-line and row-repeat count follow the mode latched at line start.

module video_address_generator #(
    parameter int unsigned ADDR_WIDTH   = 13,
    parameter int unsigned ALPHA_REPEAT = 12
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  fs_n,
    input  logic                  line_start,
    input  logic                  fetch,
    input  logic                  ag,
    input  logic [2:0]            gm,
    output logic [ADDR_WIDTH-1:0] da,
    output logic                  row_clear,
    output logic [3:0]            row_count,
    output logic                  line_overrun
);

    localparam logic [4:0] AlphaRepeat = 5'(ALPHA_REPEAT);
    localparam logic [4:0] LastIdx32   = 5'd31;
    localparam logic [4:0] LastIdx16   = 5'd15;

    // Registered state
    logic [ADDR_WIDTH-1:0] r_line_base;
    logic [4:0]            r_byte_idx;
    logic [3:0]            r_rep;
    logic                  r_first;
    logic                  r_done;
    logic                  r_alpha;      // latched alpha select
    logic                  r_b32;        // latched graphics mode uses 32 bytes per line
    logic [ADDR_WIDTH-1:0] r_da;
    logic                  r_row_clear;
    logic                  r_line_overrun;

    // Next-state values
    logic [ADDR_WIDTH-1:0] w_line_base_d;
    logic [4:0]            w_byte_idx_d;
    logic [3:0]            w_rep_d;
    logic                  w_first_d;
    logic                  w_done_d;
    logic                  w_alpha_d;
    logic                  w_b32_d;
    logic [ADDR_WIDTH-1:0] w_da_d;
    logic                  w_row_clear_d;
    logic                  w_line_overrun_d;

    // Mode decode of the live ag/gm inputs
    logic                  w_new_alpha;
    logic                  w_new_b32;
    logic [4:0]            w_new_r;

    // Geometry of the currently latched mode
    logic                  w_cur_is32;
    logic [4:0]            w_cur_last_idx;
    logic [ADDR_WIDTH-1:0] w_cur_bytes;
    logic                  w_row_wrap;

    // Decode bytes-per-line and repeat count for the mode presented now
    always_comb begin
        w_new_alpha = ~ag;
        w_new_b32   = 1'b1;
        w_new_r     = AlphaRepeat;
        if (ag) begin
            case (gm)
                3'd0, 3'd1: begin
                    w_new_b32 = 1'b0;
                    w_new_r   = 5'd3;
                end
                3'd2: begin
                    w_new_b32 = 1'b1;
                    w_new_r   = 5'd3;
                end
                3'd3: begin
                    w_new_b32 = 1'b0;
                    w_new_r   = 5'd2;
                end
                3'd4: begin
                    w_new_b32 = 1'b1;
                    w_new_r   = 5'd2;
                end
                3'd5: begin
                    w_new_b32 = 1'b0;
                    w_new_r   = 5'd1;
                end
                default: begin
                    w_new_b32 = 1'b1;
                    w_new_r   = 5'd1;
                end
            endcase
        end
    end

    // Geometry of the latched mode; alpha lines are always 32 bytes
    always_comb begin
        w_cur_is32     = r_alpha | r_b32;
        w_cur_last_idx = w_cur_is32 ? LastIdx32 : LastIdx16;
        w_cur_bytes    = w_cur_is32 ? ADDR_WIDTH'(32) : ADDR_WIDTH'(16);
        // Compare against the new R so a mode change that lowers R still
        // closes the current repeat group.
        w_row_wrap     = ({1'b0, r_rep} >= (w_new_r - 5'd1));
    end

    // Next-state logic: frame sync beats line start, line start beats fetch
    always_comb begin
        w_line_base_d    = r_line_base;
        w_byte_idx_d     = r_byte_idx;
        w_rep_d          = r_rep;
        w_first_d        = r_first;
        w_done_d         = r_done;
        w_alpha_d        = r_alpha;
        w_b32_d          = r_b32;
        w_row_clear_d    = 1'b0;
        w_line_overrun_d = 1'b0;

        if (!fs_n) begin
            w_line_base_d = '0;
            w_byte_idx_d  = '0;
            w_rep_d       = '0;
            w_first_d     = 1'b1;
            w_done_d      = 1'b0;
            w_alpha_d     = 1'b1;
            w_b32_d       = 1'b1;
        end else if (line_start) begin
            w_alpha_d        = w_new_alpha;
            w_b32_d          = w_new_b32;
            w_byte_idx_d     = '0;
            w_done_d         = 1'b0;
            // A fetch in the same cycle is dropped
            w_line_overrun_d = fetch;
            if (r_first) begin
                w_first_d     = 1'b0;
                w_line_base_d = '0;
                w_rep_d       = '0;
                w_row_clear_d = w_new_alpha;
            end else if (w_row_wrap) begin
                // Advance by the previous line's byte count
                w_rep_d       = '0;
                w_line_base_d = r_line_base + w_cur_bytes;
                w_row_clear_d = w_new_alpha;
            end else begin
                w_rep_d = r_rep + 4'd1;
            end
        end else if (fetch) begin
            if (r_first || r_done) begin
                w_line_overrun_d = 1'b1;
            end else if (r_byte_idx < w_cur_last_idx) begin
                w_byte_idx_d = r_byte_idx + 5'd1;
            end else begin
                // Last byte consumed: hold the address until next line
                w_done_d = 1'b1;
            end
        end

        w_da_d = w_line_base_d + ADDR_WIDTH'(w_byte_idx_d);
    end

    // State and output registers with asynchronous reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_line_base    <= '0;
            r_byte_idx     <= '0;
            r_rep          <= '0;
            r_first        <= 1'b1;
            r_done         <= 1'b0;
            r_alpha        <= 1'b1;
            r_b32          <= 1'b1;
            r_da           <= '0;
            r_row_clear    <= 1'b0;
            r_line_overrun <= 1'b0;
        end else begin
            r_line_base    <= w_line_base_d;
            r_byte_idx     <= w_byte_idx_d;
            r_rep          <= w_rep_d;
            r_first        <= w_first_d;
            r_done         <= w_done_d;
            r_alpha        <= w_alpha_d;
            r_b32          <= w_b32_d;
            r_da           <= w_da_d;
            r_row_clear    <= w_row_clear_d;
            r_line_overrun <= w_line_overrun_d;
        end
    end

    // Drive outputs straight from registers
    always_comb begin
        da           = r_da;
        row_clear    = r_row_clear;
        row_count    = r_rep;
        line_overrun = r_line_overrun;
    end

endmodule

// File: tb/tb_video_address_generator.sv
// Directed self-checking bench for video_address_generator.

module tb_video_address_generator;

    logic        clk;
    logic        reset;
    logic        fs_n;
    logic        line_start;
    logic        fetch;
    logic        ag;
    logic [2:0]  gm;
    logic [12:0] da;
    logic        row_clear;
    logic [3:0]  row_count;
    logic        line_overrun;

    int checks;
    int errors;

    video_address_generator #(
        .ADDR_WIDTH  (13),
        .ALPHA_REPEAT(12)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .fs_n        (fs_n),
        .line_start  (line_start),
        .fetch       (fetch),
        .ag          (ag),
        .gm          (gm),
        .da          (da),
        .row_clear   (row_clear),
        .row_count   (row_count),
        .line_overrun(line_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; outputs are observed 1 time unit after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_ls();
        line_start = 1'b1;
        step();
        line_start = 1'b0;
    endtask

    task automatic do_fetch();
        fetch = 1'b1;
        step();
        fetch = 1'b0;
    endtask

    task automatic new_frame();
        fs_n = 1'b0;
        step();
        fs_n = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #3;
        checks++;
        if (da !== 13'd0) begin
            errors++;
            $display("FAIL reset_da: got %0d expected 0", da);
        end
        checks++;
        if ({row_clear, line_overrun, row_count} !== 6'd0) begin
            errors++;
            $display("FAIL reset_flags: got rc=%b ov=%b cnt=%0d expected all 0",
                     row_clear, line_overrun, row_count);
        end
        step();
        reset = 1'b0;
        step();
    endtask

    task automatic test_graphics16();
        logic [12:0] exp;
        ag = 1'b1;
        gm = 3'd5;
        new_frame();
        do_ls();
        checks++;
        if (da !== 13'd0 || row_clear !== 1'b0) begin
            errors++;
            $display("FAIL g5_first_ls: got da=%0d rc=%b expected da=0 rc=0", da, row_clear);
        end
        for (int i = 0; i < 16; i++) begin
            do_fetch();
            exp = (i < 15) ? 13'(i + 1) : 13'd15;
            checks++;
            if (da !== exp || row_clear !== 1'b0 || line_overrun !== 1'b0) begin
                errors++;
                $display("FAIL g5_fetch%0d: got da=%0d rc=%b ov=%b expected da=%0d rc=0 ov=0",
                         i, da, row_clear, line_overrun, exp);
            end
        end
        do_ls();
        checks++;
        if (da !== 13'd16 || row_count !== 4'd0 || row_clear !== 1'b0) begin
            errors++;
            $display("FAIL g5_second_ls: got da=%0d cnt=%0d rc=%b expected 16 0 0",
                     da, row_count, row_clear);
        end
    endtask

    // Continues from test_graphics16: line 2 at base 16, gm=5
    task automatic test_overrun();
        for (int i = 0; i < 16; i++) do_fetch();
        checks++;
        if (da !== 13'd31 || line_overrun !== 1'b0) begin
            errors++;
            $display("FAIL ovr_line_end: got da=%0d ov=%b expected 31 0", da, line_overrun);
        end
        do_fetch();
        checks++;
        if (da !== 13'd31 || line_overrun !== 1'b1) begin
            errors++;
            $display("FAIL ovr_extra_fetch: got da=%0d ov=%b expected 31 1", da, line_overrun);
        end
        step();
        checks++;
        if (line_overrun !== 1'b0) begin
            errors++;
            $display("FAIL ovr_pulse_end: got ov=%b expected 0", line_overrun);
        end
        line_start = 1'b1;
        fetch      = 1'b1;
        step();
        line_start = 1'b0;
        fetch      = 1'b0;
        checks++;
        if (da !== 13'd32 || line_overrun !== 1'b1) begin
            errors++;
            $display("FAIL ovr_coincident: got da=%0d ov=%b expected 32 1", da, line_overrun);
        end
        step();
        checks++;
        if (da !== 13'd32 || line_overrun !== 1'b0) begin
            errors++;
            $display("FAIL ovr_coincident_next: got da=%0d ov=%b expected 32 0",
                     da, line_overrun);
        end
        do_fetch();
        checks++;
        if (da !== 13'd33) begin
            errors++;
            $display("FAIL ovr_resume: got da=%0d expected 33", da);
        end
    endtask

    task automatic test_alpha();
        logic [12:0] base;
        logic [12:0] exp;
        logic        exp_rc;
        logic [3:0]  exp_cnt;
        ag = 1'b0;
        gm = 3'd0;
        new_frame();
        for (int l = 0; l < 13; l++) begin
            do_ls();
            base    = (l < 12) ? 13'd0 : 13'd32;
            exp_rc  = (l == 0 || l == 12);
            exp_cnt = (l < 12) ? 4'(l) : 4'd0;
            checks++;
            if (da !== base || row_clear !== exp_rc || row_count !== exp_cnt) begin
                errors++;
                $display("FAIL alpha_ls%0d: got da=%0d rc=%b cnt=%0d expected da=%0d rc=%b cnt=%0d",
                         l + 1, da, row_clear, row_count, base, exp_rc, exp_cnt);
            end
            for (int i = 0; i < 32; i++) begin
                do_fetch();
                exp = base + ((i < 31) ? 13'(i + 1) : 13'd31);
                checks++;
                if (da !== exp || row_clear !== 1'b0) begin
                    errors++;
                    $display("FAIL alpha_line%0d_fetch%0d: got da=%0d rc=%b expected da=%0d rc=0",
                             l + 1, i, da, row_clear, exp);
                end
            end
        end
    endtask

    task automatic test_graphics_rows();
        logic [12:0] base;
        ag = 1'b1;
        gm = 3'd0;
        new_frame();
        for (int l = 0; l < 6; l++) begin
            do_ls();
            base = (l < 3) ? 13'd0 : 13'd16;
            checks++;
            if (da !== base || row_count !== 4'(l % 3) || row_clear !== 1'b0) begin
                errors++;
                $display("FAIL gm0_line%0d: got da=%0d cnt=%0d rc=%b expected da=%0d cnt=%0d rc=0",
                         l + 1, da, row_count, row_clear, base, l % 3);
            end
            for (int i = 0; i < 16; i++) do_fetch();
            checks++;
            if (da !== base + 13'd15) begin
                errors++;
                $display("FAIL gm0_line%0d_end: got da=%0d expected %0d", l + 1, da, base + 15);
            end
        end
        gm = 3'd4;
        new_frame();
        for (int l = 0; l < 4; l++) begin
            do_ls();
            base = (l < 2) ? 13'd0 : 13'd32;
            checks++;
            if (da !== base || row_count !== 4'(l % 2)) begin
                errors++;
                $display("FAIL gm4_line%0d: got da=%0d cnt=%0d expected da=%0d cnt=%0d",
                         l + 1, da, row_count, base, l % 2);
            end
            for (int i = 0; i < 32; i++) do_fetch();
            checks++;
            if (da !== base + 13'd31) begin
                errors++;
                $display("FAIL gm4_line%0d_end: got da=%0d expected %0d", l + 1, da, base + 31);
            end
        end
    endtask

    task automatic test_wrap();
        logic [12:0] base;
        ag = 1'b1;
        gm = 3'd7;
        new_frame();
        for (int l = 0; l < 256; l++) begin
            do_ls();
            base = 13'((32 * l) % 8192);
            checks++;
            if (da !== base || row_count !== 4'd0) begin
                errors++;
                $display("FAIL wrap_line%0d: got da=%0d cnt=%0d expected da=%0d cnt=0",
                         l + 1, da, row_count, base);
            end
            for (int i = 0; i < 32; i++) do_fetch();
        end
        checks++;
        if (da !== 13'd8191) begin
            errors++;
            $display("FAIL wrap_last_byte: got da=%0d expected 8191", da);
        end
        do_ls();
        checks++;
        if (da !== 13'd0) begin
            errors++;
            $display("FAIL wrap_to_zero: got da=%0d expected 0", da);
        end
        for (int i = 0; i < 3; i++) do_fetch();
        checks++;
        if (da !== 13'd3) begin
            errors++;
            $display("FAIL wrap_after_fetch: got da=%0d expected 3", da);
        end
        fs_n = 1'b0;
        step();
        fs_n = 1'b1;
        checks++;
        if (da !== 13'd0 || row_count !== 4'd0) begin
            errors++;
            $display("FAIL fsn_clear: got da=%0d cnt=%0d expected 0 0", da, row_count);
        end
        do_fetch();
        checks++;
        if (da !== 13'd0 || line_overrun !== 1'b1) begin
            errors++;
            $display("FAIL fsn_fetch_before_ls: got da=%0d ov=%b expected 0 1", da, line_overrun);
        end
    endtask

    task automatic test_async_reset();
        ag = 1'b1;
        gm = 3'd7;
        new_frame();
        do_ls();
        for (int i = 0; i < 32; i++) do_fetch();
        do_ls();
        for (int i = 0; i < 5; i++) do_fetch();
        checks++;
        if (da !== 13'd37) begin
            errors++;
            $display("FAIL areset_setup: got da=%0d expected 37", da);
        end
        reset = 1'b1;
        #2;
        checks++;
        if (da !== 13'd0 || {row_clear, line_overrun, row_count} !== 6'd0) begin
            errors++;
            $display("FAIL areset_async: got da=%0d rc=%b ov=%b cnt=%0d expected all 0",
                     da, row_clear, line_overrun, row_count);
        end
        #2;
        reset = 1'b0;
        ag    = 1'b0;
        do_ls();
        checks++;
        if (da !== 13'd0 || row_count !== 4'd0 || row_clear !== 1'b1) begin
            errors++;
            $display("FAIL areset_first_ls: got da=%0d cnt=%0d rc=%b expected 0 0 1",
                     da, row_count, row_clear);
        end
        do_fetch();
        checks++;
        if (da !== 13'd1 || row_clear !== 1'b0) begin
            errors++;
            $display("FAIL areset_first_fetch: got da=%0d rc=%b expected 1 0", da, row_clear);
        end
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        reset      = 1'b1;
        fs_n       = 1'b1;
        line_start = 1'b0;
        fetch      = 1'b0;
        ag         = 1'b0;
        gm         = 3'd0;

        test_reset();
        test_graphics16();
        test_overrun();
        test_alpha();
        test_graphics_rows();
        test_wrap();
        test_async_reset();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
